// File: rtl/timer_pkg.sv
// Shared types and helpers for the parametrised timer.
// The prescaler is built only when TIMER_PRESCALER_EN is defined.
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } timer_state_t;

    // A single-cycle prescaler still needs one bit of storage.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Step-enable generator: pulses step once every PRESCALE enabled cycles.
// Instantiated by timer_param only when TIMER_PRESCALER_EN is defined.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int unsigned PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_count;

    assign step = enable && (pre_count == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre_count <= '0;
        end else if (clear) begin
            pre_count <= '0;
        end else if (step) begin
            pre_count <= '0;
        end else if (enable) begin
            pre_count <= pre_count + PW'(1);
        end
    end

endmodule

// File: rtl/timer_param.sv
// Parametrised up-counter timer with one-shot/periodic modes and expiry pulse.
// Optional step prescaler enabled by defining TIMER_PRESCALER_EN.
//
// state | meaning
// IDLE  | cleared, count 0, not yet stepped
// RUN   | counting toward timer_final_value
// DONE  | one-shot expired, count held until clear/reset
module timer_param
    import timer_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             timer_active,
    input  logic             mode_periodic,
    input  logic [WIDTH-1:0] timer_final_value,
    output logic [WIDTH-1:0] timer_count,
    output logic             timer_tick,
    output logic             timer_done
);

    timer_state_t     state, next_state;
    logic [WIDTH-1:0] next_count;
    logic             next_tick;
    logic             step;

`ifdef TIMER_PRESCALER_EN
    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .resetn (resetn),
        .clear  (clear),
        .enable (timer_active && (state != DONE)),
        .step   (step)
    );
`else
    assign step = timer_active;
`endif

    assign timer_done = (state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            timer_count <= '0;
            timer_tick  <= 1'b0;
        end else begin
            state       <= next_state;
            timer_count <= next_count;
            timer_tick  <= next_tick;
        end
    end

    // Compare is >= so a final value lowered below the count expires instead of wrapping.
    always_comb begin
        next_state = state;
        next_count = timer_count;
        next_tick  = 1'b0;
        if (clear) begin
            next_state = IDLE;
            next_count = '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (step) begin
                        next_state = RUN;
                        if (timer_count >= timer_final_value) begin
                            next_tick = 1'b1;
                            if (mode_periodic) begin
                                next_count = '0;
                            end else begin
                                next_state = DONE;
                            end
                        end else begin
                            next_count = timer_count + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    next_state = DONE;
                end
                default: begin
                    next_state = IDLE;
                    next_count = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_param.md
Name: timer_param

Overview:
- Parametrised up-counter timer; successor to the fixed 10-bit timer.
- Counts active cycles up to a programmable final value, then reports expiry.
- Adds one-shot vs periodic (auto-reload) mode, pause, synchronous clear, a one-cycle expiry pulse, and a live count output.
- Used by the UART/Bluetooth control FSMs for baud spacing, timeouts and periodic sampling.

Parameters:
- WIDTH, 10, counter and final-value width in bits (>=2).
- PRESCALE, 1, active cycles per count step; only used when TIMER_PRESCALER_EN is defined (>=1).

Ports:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: count to 0, state to IDLE.
- timer_active  in  1  count enable; low pauses the timer.
- mode_periodic  in  1  1 = auto-reload on expiry, 0 = one-shot.
- timer_final_value  in  WIDTH  terminal count N.
- timer_count  out  WIDTH  current count.
- timer_tick  out  1  registered one-cycle pulse per expiry.
- timer_done  out  1  level; high while in DONE (one-shot expired).

Behaviour:
- Reset (resetn=0, async): state=IDLE, timer_count=0, timer_tick=0, timer_done=0, prescaler=0.
- States: IDLE (count 0, not started), RUN, DONE. Encoding IDLE=00, RUN=01, DONE=10.
- Priority each edge: resetn > clear > timer_active.
- clear=1: count<=0, state<=IDLE, tick<=0, prescaler<=0, regardless of timer_active or state.
- Count step: an edge in IDLE or RUN with timer_active=1 (and prescaler wrap, if enabled).
- On a step:
  - IDLE goes to RUN.
  - If count >= timer_final_value: expiry.
  - Otherwise count<=count+1.
- Expiry:
  - tick<=1 for exactly the following cycle.
  - mode_periodic=1: count<=0, state RUN.
  - mode_periodic=0: count held, state<=DONE.
- Latency: with active held high from IDLE, tick is high in cycle N+1 after the first active edge.
  - Periodic period = N+1 steps.
  - N=0 expires on the first step, giving tick every cycle in periodic mode.
- timer_active=0 in IDLE/RUN: count, state and prescaler hold; tick<=0.
- DONE: timer_active and mode_periodic ignored; count held; done=1; tick=0. Exit only via clear or reset.
- Compare is live against timer_final_value.
  - The >= compare covers lowering the final value below the current count mid-run: expiry on the next step, no wrap.
  - Raising it extends the run.
- mode_periodic is sampled only at the expiry edge.
- Count never exceeds max(final, count at last change); no arithmetic overflow; increment is modulo 2^WIDTH but unreachable past all-ones.
- Reset mid-run: immediate return to reset values; no tick is generated.

Optional Feature:
- TIMER_PRESCALER_EN defined:
  - A prescaler counter of $clog2(PRESCALE) bits (min 1) increments on active cycles.
  - A count step occurs only on the cycle it equals PRESCALE-1, at which point it wraps to 0.
  - The prescaler holds when inactive and clears on clear/reset.
  - PRESCALE=1 behaves identically to undefined.
- Undefined: every active cycle is a step; PRESCALE is ignored and no prescaler logic is built.

Decomposition:
- Package timer_pkg holds:
  - the state typedef timer_state_t (IDLE/RUN/DONE);
  - localparams for the state encodings;
  - a function computing prescaler width from PRESCALE.
- One natural sub-module, timer_prescaler: step-enable generator, instantiated only under TIMER_PRESCALER_EN.
- Counter and FSM stay in timer_param.

Test Plan:
- One-shot:
  - Stimulus: WIDTH=10, N=5, active=1 continuously from IDLE.
  - Required: tick high exactly once, 6 cycles after first active edge; done=1 thereafter; count stays 5; further active has no effect.
- Periodic with pause:
  - Stimulus: N=3, mode_periodic=1, active low for 2 cycles mid-count.
  - Required: tick every 4 active cycles; count sequence 0,1,2,3,0 with pauses holding value; no tick during pause.
- Boundaries:
  - N=0 periodic: tick every cycle.
  - N=1023 one-shot: tick after 1024 steps; count never wraps.
  - Lowering N from 8 to 2 while count=5: expiry on next step.
- Clear/priority:
  - clear and active both high in RUN at count=4: next cycle count=0, state IDLE, tick=0.
  - clear in DONE: done drops next cycle.
- Reset: resetn pulsed low asynchronously mid-run at count=7 (between edges) -> count, tick, done read 0 immediately.
- Prescaler (TIMER_PRESCALER_EN, PRESCALE=4, N=2):
  - Required: count advances every 4 active cycles; tick after 12 active cycles.
  - Repeat with macro undefined: tick after 3 active cycles.
